sdram_port_arbiter: RTL and testbench

- Multi-port successor to the single-reader/single-writer SDRAM facade.
- Arbitrates NumPorts independent pixel clients, each able to request read or write bursts, onto one SDRAM controller command/data interface.
- Each port owns a private frame region with its own burst address counter, so several frame buffers (capture, display, overlay) can share one SDRAM.

---
 rtl/sdram_port_arbiter.sv | 205 ++++++++++++++++++++
 tb/tb_sdram_port_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sdram_port_arbiter
// Brief    : Multi-port burst arbiter sharing one SDRAM controller; each port
//            streams through its own frame region with a private address counter.
// Revision : 1.0 - initial release
// ============================================================================
module sdram_port_arbiter #(
    parameter int NUM_PORTS           = 2,
    parameter int PIXEL_BIT_WIDTH     = 16,
    parameter int ADDRESS_WIDTH_SDRAM = 24,
    parameter int BURST_LENGTH_SDRAM  = 8,
    parameter int FRAME_WORDS         = 307200,
    parameter bit ROUND_ROBIN         = 1'b1
) (
    input  logic                                 CLK,
    input  logic                                 RST,
    input  logic [NUM_PORTS-1:0]                 i_req,
    input  logic [NUM_PORTS-1:0]                 i_rw,
    input  logic [NUM_PORTS-1:0]                 i_frame_restart,
    input  logic [NUM_PORTS*PIXEL_BIT_WIDTH-1:0] i_wdata,
    output logic [NUM_PORTS-1:0]                 o_grant,
    output logic [NUM_PORTS-1:0]                 o_wr_ack,
    output logic [NUM_PORTS-1:0]                 o_rd_valid,
    output logic [PIXEL_BIT_WIDTH-1:0]           o_rdata,
    output logic                                 o_busy,
    input  logic                                 i_sdram_busy,
    input  logic                                 i_sdram_valid_wr,
    input  logic                                 i_sdram_valid_rd,
    input  logic [PIXEL_BIT_WIDTH-1:0]           i_sdram_pixel,
    output logic                                 o_sdram_enable,
    output logic                                 o_sdram_read,
    output logic [PIXEL_BIT_WIDTH-1:0]           o_sdram_pixel,
    output logic [ADDRESS_WIDTH_SDRAM-1:0]       o_sdram_addr
);
    localparam int c_IDX_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int c_OFF_W  = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
    localparam int c_SUM_W  = c_OFF_W + 1;
    localparam int c_BEAT_W = (BURST_LENGTH_SDRAM > 1) ? $clog2(BURST_LENGTH_SDRAM) : 1;
    localparam logic [c_SUM_W-1:0]             c_FRAME_SUM  = c_SUM_W'(FRAME_WORDS);
    localparam logic [c_SUM_W-1:0]             c_BURST_SUM  = c_SUM_W'(BURST_LENGTH_SDRAM);
    localparam logic [ADDRESS_WIDTH_SDRAM-1:0] c_FRAME_ADDR = ADDRESS_WIDTH_SDRAM'(FRAME_WORDS);
    localparam logic [c_BEAT_W-1:0]            c_LAST_BEAT  = c_BEAT_W'(BURST_LENGTH_SDRAM - 1);
    localparam logic [c_IDX_W-1:0]             c_RR_RESET   = c_IDX_W'(NUM_PORTS - 1);

    generate
        if ((NUM_PORTS < 1) || (NUM_PORTS > 8) ||
            (longint'(NUM_PORTS) * longint'(FRAME_WORDS) > (longint'(1) << ADDRESS_WIDTH_SDRAM))) begin : g_param_check
            $error("sdram_port_arbiter: port count out of range or regions exceed SDRAM address space");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_BURST = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t                   r_state;
    state_t                   w_state_next;
    logic [NUM_PORTS-1:0]     r_grant;
    logic [c_IDX_W-1:0]       r_win_idx;
    logic                     r_rw;
    logic [c_BEAT_W-1:0]      r_beat_cnt;
    logic [c_IDX_W-1:0]       r_rr_ptr;
    logic [c_OFF_W-1:0]       r_offset [NUM_PORTS];
    logic [NUM_PORTS-1:0]     r_restart_pend;
    logic [NUM_PORTS-1:0]     r_rd_valid;
    logic [PIXEL_BIT_WIDTH-1:0] r_rdata;

    logic                     w_win_found;
    logic [c_IDX_W-1:0]       w_win_idx;
    logic                     w_grant_load;
    logic                     w_drain_exit;
    logic                     w_beat;
    logic                     w_issue;
    logic                     w_wr_beat;
    logic                     w_rd_beat;
    logic [c_OFF_W-1:0]       w_cur_off;
    logic [c_SUM_W-1:0]       w_off_sum;
    logic [c_OFF_W-1:0]       w_off_next;

    // Round robin scans starting one past the last winner, wrapping cyclically.
    always_comb begin
        w_win_found = 1'b0;
        w_win_idx   = '0;
        for (int n = 0; n < NUM_PORTS; n++) begin
            int j;
            if (ROUND_ROBIN) begin
                j = int'(r_rr_ptr) + 1 + n;
                if (j >= NUM_PORTS) j = j - NUM_PORTS;
            end else begin
                j = n;
            end
            if (!w_win_found && i_req[j]) begin
                w_win_found = 1'b1;
                w_win_idx   = c_IDX_W'(j);
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_grant_load = 1'b0;
        w_drain_exit = 1'b0;
        w_beat       = 1'b0;
        w_issue      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!i_sdram_busy && w_win_found) begin
                    w_grant_load = 1'b1;
                    w_state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_issue = 1'b1;
                if (i_sdram_busy) w_state_next = S_BURST;
            end
            S_BURST: begin
                w_beat = r_rw ? i_sdram_valid_rd : i_sdram_valid_wr;
                if (w_beat && (r_beat_cnt == c_LAST_BEAT)) w_state_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (!i_sdram_busy) begin
                    w_drain_exit = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state    <= S_IDLE;
            r_grant    <= '0;
            r_win_idx  <= '0;
            r_rw       <= 1'b0;
            r_beat_cnt <= '0;
            r_rr_ptr   <= c_RR_RESET;
        end else begin
            r_state <= w_state_next;
            if (w_grant_load) begin
                r_grant    <= NUM_PORTS'(1) << w_win_idx;
                r_win_idx  <= w_win_idx;
                r_rw       <= i_rw[w_win_idx];
                r_beat_cnt <= '0;
                r_rr_ptr   <= w_win_idx;
            end else if (w_drain_exit) begin
                r_grant <= '0;
            end
            if (w_beat) r_beat_cnt <= r_beat_cnt + c_BEAT_W'(1);
        end
    end

    assign w_cur_off  = r_offset[r_win_idx];
    assign w_off_sum  = {1'b0, w_cur_off} + c_BURST_SUM;
    assign w_off_next = (w_off_sum >= c_FRAME_SUM) ? '0 : w_off_sum[c_OFF_W-1:0];

    // A restart on the owning port is deferred so the in-flight burst keeps its address.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            for (int p = 0; p < NUM_PORTS; p++) r_offset[p] <= '0;
            r_restart_pend <= '0;
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (w_drain_exit && r_grant[p]) begin
                    r_offset[p]       <= (r_restart_pend[p] || i_frame_restart[p]) ? '0 : w_off_next;
                    r_restart_pend[p] <= 1'b0;
                end else if (i_frame_restart[p]) begin
                    if (r_grant[p]) r_restart_pend[p] <= 1'b1;
                    else            r_offset[p]       <= '0;
                end
            end
        end
    end

    assign w_wr_beat = (r_state == S_BURST) && !r_rw && i_sdram_valid_wr;
    assign w_rd_beat = (r_state == S_BURST) &&  r_rw && i_sdram_valid_rd;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_rdata    <= '0;
            r_rd_valid <= '0;
        end else begin
            r_rdata    <= i_sdram_pixel;
            r_rd_valid <= r_grant & {NUM_PORTS{w_rd_beat}};
        end
    end

    assign o_grant        = r_grant;
    assign o_busy         = (r_state != S_IDLE);
    assign o_wr_ack       = r_grant & {NUM_PORTS{w_wr_beat}};
    assign o_rd_valid     = r_rd_valid;
    assign o_rdata        = r_rdata;
    assign o_sdram_enable = w_issue;
    assign o_sdram_read   = w_issue & r_rw;
    assign o_sdram_addr   = w_issue ? (ADDRESS_WIDTH_SDRAM'(r_win_idx) * c_FRAME_ADDR
                                       + ADDRESS_WIDTH_SDRAM'(w_cur_off)) : '0;
    assign o_sdram_pixel  = (|r_grant) ?
                            i_wdata[int'(r_win_idx)*PIXEL_BIT_WIDTH +: PIXEL_BIT_WIDTH] : '0;

endmodule
`default_nettype wire

// File: tb/tb_sdram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdram_port_arbiter
// Brief    : Scoreboard bench for sdram_port_arbiter; instance 0 is round robin
//            with full frames, instance 1 fixed priority with 24-word frames.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sdram_port_arbiter;
    localparam int FRAME0 = 307200;
    localparam int FRAME1 = 24;

    logic        CLK = 1'b0;
    logic        rst_n      [2];
    logic [1:0]  req        [2];
    logic [1:0]  rw         [2];
    logic [1:0]  restart    [2];
    logic [31:0] wdata      [2];
    logic [1:0]  grant      [2];
    logic [1:0]  wr_ack     [2];
    logic [1:0]  rd_valid   [2];
    logic [15:0] rdata      [2];
    logic        busy       [2];
    logic        sd_busy    [2];
    logic        v_wr       [2];
    logic        v_rd       [2];
    logic [15:0] sd_pix_in  [2];
    logic        en         [2];
    logic        rd_cmd     [2];
    logic [15:0] sd_pix_out [2];
    logic [23:0] sd_addr    [2];

    typedef struct { int port; bit rw; int addr; } cmd_t;
    typedef struct { int port; int data; } dat_t;
    cmd_t cmd_q [2][$];
    dat_t ack_q [2][$];
    dat_t rd_q  [2][$];
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   prev_en [2];

    always #5 CLK = ~CLK;

    sdram_port_arbiter #(.NUM_PORTS(2), .PIXEL_BIT_WIDTH(16), .ADDRESS_WIDTH_SDRAM(24),
        .BURST_LENGTH_SDRAM(8), .FRAME_WORDS(FRAME0), .ROUND_ROBIN(1'b1)) u_dut_rr (
        .CLK(CLK), .RST(rst_n[0]), .i_req(req[0]), .i_rw(rw[0]), .i_frame_restart(restart[0]),
        .i_wdata(wdata[0]), .o_grant(grant[0]), .o_wr_ack(wr_ack[0]), .o_rd_valid(rd_valid[0]),
        .o_rdata(rdata[0]), .o_busy(busy[0]), .i_sdram_busy(sd_busy[0]),
        .i_sdram_valid_wr(v_wr[0]), .i_sdram_valid_rd(v_rd[0]), .i_sdram_pixel(sd_pix_in[0]),
        .o_sdram_enable(en[0]), .o_sdram_read(rd_cmd[0]), .o_sdram_pixel(sd_pix_out[0]),
        .o_sdram_addr(sd_addr[0]));

    sdram_port_arbiter #(.NUM_PORTS(2), .PIXEL_BIT_WIDTH(16), .ADDRESS_WIDTH_SDRAM(24),
        .BURST_LENGTH_SDRAM(8), .FRAME_WORDS(FRAME1), .ROUND_ROBIN(1'b0)) u_dut_fp (
        .CLK(CLK), .RST(rst_n[1]), .i_req(req[1]), .i_rw(rw[1]), .i_frame_restart(restart[1]),
        .i_wdata(wdata[1]), .o_grant(grant[1]), .o_wr_ack(wr_ack[1]), .o_rd_valid(rd_valid[1]),
        .o_rdata(rdata[1]), .o_busy(busy[1]), .i_sdram_busy(sd_busy[1]),
        .i_sdram_valid_wr(v_wr[1]), .i_sdram_valid_rd(v_rd[1]), .i_sdram_pixel(sd_pix_in[1]),
        .o_sdram_enable(en[1]), .o_sdram_read(rd_cmd[1]), .o_sdram_pixel(sd_pix_out[1]),
        .o_sdram_addr(sd_addr[1]));

    task automatic check_cmd(input int k);
        cmd_t       c;
        logic [1:0] eg;
        n_tests++;
        if (cmd_q[k].size() == 0) begin
            n_fail++;
            $display("FAIL cmd[%0d] unexpected command grant=%b addr=%0d", k, grant[k], sd_addr[k]);
            return;
        end
        c  = cmd_q[k].pop_front();
        eg = 2'b01 << c.port;
        if (grant[k] !== eg || rd_cmd[k] !== c.rw || sd_addr[k] !== 24'(c.addr)) begin
            n_fail++;
            $display("FAIL cmd[%0d] got grant=%b read=%b addr=%0d, expected grant=%b read=%b addr=%0d",
                     k, grant[k], rd_cmd[k], sd_addr[k], eg, c.rw, c.addr);
        end
    endtask

    task automatic check_dat(input int k, input bit is_rd);
        dat_t       d;
        logic [1:0] ev;
        logic [1:0] gv;
        logic [15:0] gd;
        gv = is_rd ? rd_valid[k] : wr_ack[k];
        gd = is_rd ? rdata[k] : sd_pix_out[k];
        n_tests++;
        if ((is_rd ? rd_q[k].size() : ack_q[k].size()) == 0) begin
            n_fail++;
            $display("FAIL %s[%0d] unexpected strobe=%b data=%h", is_rd ? "rd" : "ack", k, gv, gd);
            return;
        end
        d  = is_rd ? rd_q[k].pop_front() : ack_q[k].pop_front();
        ev = 2'b01 << d.port;
        if (gv !== ev || gd !== 16'(d.data)) begin
            n_fail++;
            $display("FAIL %s[%0d] got strobe=%b data=%h, expected strobe=%b data=%h",
                     is_rd ? "rd" : "ack", k, gv, gd, ev, 16'(d.data));
        end
    endtask

    initial begin
        prev_en = '{1'b0, 1'b0};
        forever begin
            @(negedge CLK);
            #2;
            for (int k = 0; k < 2; k++) begin
                if (en[k] === 1'b1 && !prev_en[k]) check_cmd(k);
                prev_en[k] = (en[k] === 1'b1);
                if (wr_ack[k] != 2'b00)   check_dat(k, 1'b0);
                if (rd_valid[k] != 2'b00) check_dat(k, 1'b1);
            end
        end
    end

    task automatic check_idle(input int k, input string name);
        n_tests++;
        if ({grant[k], busy[k], en[k], rd_cmd[k], wr_ack[k], rd_valid[k]} !== 8'h00) begin
            n_fail++;
            $display("FAIL %s[%0d] control got grant=%b busy=%b en=%b read=%b ack=%b rdv=%b, expected all 0",
                     name, k, grant[k], busy[k], en[k], rd_cmd[k], wr_ack[k], rd_valid[k]);
        end
        n_tests++;
        if ({rdata[k], sd_pix_out[k], sd_addr[k]} !== 56'h0) begin
            n_fail++;
            $display("FAIL %s[%0d] data got rdata=%h pixel=%h addr=%0d, expected 0",
                     name, k, rdata[k], sd_pix_out[k], sd_addr[k]);
        end
    endtask

    task automatic wait_en(input int k, output bit ok);
        int t = 0;
        while (en[k] !== 1'b1 && t < 40) begin
            @(negedge CLK);
            t++;
        end
        ok = (en[k] === 1'b1);
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL timeout[%0d] no command strobe within 40 cycles, got en=%b expected 1", k, en[k]);
        end
    endtask

    // Plays the controller for one burst; expectations are queued before the command appears.
    task automatic run_burst(input int k, input int port, input bit dir, input int addr,
                             input logic [1:0] rel, input int restart_beat);
        cmd_t c;
        dat_t d;
        bit   ok;
        c.port = port; c.rw = dir; c.addr = addr;
        cmd_q[k].push_back(c);
        wait_en(k, ok);
        if (!ok) return;
        req[k]     = req[k] & ~rel;
        sd_busy[k] = 1'b1;
        @(negedge CLK);
        for (int b = 0; b < 8; b++) begin
            d.port = port;
            if (dir) begin
                d.data       = 'hA000 + b;
                sd_pix_in[k] = 16'(d.data);
                v_rd[k]      = 1'b1;
                rd_q[k].push_back(d);
            end else begin
                d.data = 'h5000 + port * 'h100 + b;
                wdata[k][port*16 +: 16] = 16'(d.data);
                v_wr[k] = 1'b1;
                ack_q[k].push_back(d);
            end
            if (b == restart_beat) restart[k][port] = 1'b1;
            @(negedge CLK);
            restart[k] = 2'b00;
        end
        v_wr[k]    = 1'b0;
        v_rd[k]    = 1'b0;
        sd_busy[k] = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        dat_t d;
        cmd_t c;
        bit   ok;
        for (int k = 0; k < 2; k++) begin
            rst_n[k] = 1'b0; req[k] = '0; rw[k] = '0; restart[k] = '0;
            wdata[k] = 32'h1234_9876; sd_busy[k] = 1'b0; v_wr[k] = 1'b0; v_rd[k] = 1'b0;
            sd_pix_in[k] = 16'h0;
        end
        repeat (3) @(negedge CLK);
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        @(negedge CLK); #2;
        check_idle(0, "reset");
        check_idle(1, "reset");
        @(negedge CLK);

        // Round robin instance: single writes, then alternating contention
        req[0] = 2'b01; rw[0] = 2'b00;
        run_burst(0, 0, 1'b0, 0, 2'b01, -1);
        req[0] = 2'b01;
        run_burst(0, 0, 1'b0, 8, 2'b01, -1);
        req[0] = 2'b11; rw[0] = 2'b10;
        run_burst(0, 1, 1'b1, FRAME0,     2'b00, -1);
        run_burst(0, 0, 1'b0, 16,         2'b00, -1);
        run_burst(0, 1, 1'b1, FRAME0 + 8, 2'b00, -1);
        run_burst(0, 0, 1'b0, 24,         2'b11, -1);
        req[0] = 2'b01; rw[0] = 2'b00;
        run_burst(0, 0, 1'b0, 32, 2'b01, 3);
        req[0] = 2'b01;
        run_burst(0, 0, 1'b0, 0, 2'b01, -1);
        restart[0] = 2'b10;
        @(negedge CLK);
        restart[0] = 2'b00;
        req[0] = 2'b10; rw[0] = 2'b10;
        run_burst(0, 1, 1'b1, FRAME0, 2'b10, -1);

        // Reset three beats into a read burst
        req[0] = 2'b10; rw[0] = 2'b10;
        c.port = 1; c.rw = 1'b1; c.addr = FRAME0 + 8;
        cmd_q[0].push_back(c);
        wait_en(0, ok);
        req[0] = 2'b00;
        sd_busy[0] = 1'b1;
        @(negedge CLK);
        for (int b = 0; b < 3; b++) begin
            d.port = 1; d.data = 'hB000 + b;
            sd_pix_in[0] = 16'(d.data);
            v_rd[0] = 1'b1;
            rd_q[0].push_back(d);
            @(negedge CLK);
        end
        v_rd[0] = 1'b0; sd_busy[0] = 1'b0; rst_n[0] = 1'b0;
        @(negedge CLK); #2;
        check_idle(0, "midreset");
        @(negedge CLK);
        rst_n[0] = 1'b1;
        sd_pix_in[0] = 16'hDEAD;
        repeat (3) begin
            v_rd[0] = 1'b1; v_wr[0] = 1'b1;
            @(negedge CLK);
        end
        v_rd[0] = 1'b0; v_wr[0] = 1'b0;
        @(negedge CLK);
        req[0] = 2'b01; rw[0] = 2'b00;
        run_burst(0, 0, 1'b0, 0, 2'b01, -1);
        req[0] = 2'b10; rw[0] = 2'b10;
        run_burst(0, 1, 1'b1, FRAME0, 2'b10, -1);

        // Fixed priority instance: port 0 starves port 1, offset wraps at 24 words
        req[1] = 2'b11; rw[1] = 2'b00;
        run_burst(1, 0, 1'b0, 0,      2'b00, -1);
        run_burst(1, 0, 1'b0, 8,      2'b00, -1);
        run_burst(1, 0, 1'b0, 16,     2'b00, -1);
        run_burst(1, 0, 1'b0, 0,      2'b01, -1);
        run_burst(1, 1, 1'b0, FRAME1, 2'b10, -1);

        repeat (5) @(negedge CLK);
        for (int k = 0; k < 2; k++) begin
            n_tests++;
            if (cmd_q[k].size() + ack_q[k].size() + rd_q[k].size() != 0) begin
                n_fail++;
                $display("FAIL drain[%0d] leftover cmd=%0d ack=%0d rd=%0d, expected 0 0 0",
                         k, cmd_q[k].size(), ack_q[k].size(), rd_q[k].size());
            end
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
